spi_flash_resp: RTL

Synthesizable SPI NOR-flash responder: the target end of the serial flash link, answering the same command set our flash initiator issues (status read, write-enable, status write, JEDEC ID, data read). The block runs in the system `ACLK` domain and oversamples `CLOCK`/`CS`/`IO0` from the pins. It serves read data from an external byte-wide memory port. It is used as a loopback target on the second GPIO header and as a bench model for initiator bring-up.

---
 rtl/spi_flash_resp.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI NOR-flash target serving status, WREN/WRDI, WRSR, JEDEC ID and READ in the ACLK domain.
// Optional macro SPI_RESP_QUAD_EN adds the 0x6B quad-output fast read (DUMMY state and nibble output path).
module spi_flash_resp #(
    parameter int          ADDR_SIZE = 24,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 CS,
    input  logic                 CLOCK,
    input  logic [3:0]           io_in,
    output logic [3:0]           io_out,
    output logic [3:0]           io_oe,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_rdata,
    output logic [7:0]           status_reg,
    output logic                 cmd_done
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        ADDR     = 3'd2,
`ifdef SPI_RESP_QUAD_EN
        DUMMY    = 3'd3,
`endif
        DATA_OUT = 3'd4,
        SR_WR    = 3'd5,
        IGNORE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_STATUS = 2'd0,
        SRC_JEDEC  = 2'd1,
        SRC_MEM    = 2'd2
    } src_t;

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [2:0]           cs_sync_q, cs_sync_d;
    logic [1:0]           io0_sync_q, io0_sync_d;
    state_t               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [22:0]          shift_q, shift_d;
    logic [2:0]           out_cnt_q, out_cnt_d;
    logic [7:0]           out_sh_q, out_sh_d;
    src_t                 src_q, src_d;
    logic [1:0]           jed_idx_q, jed_idx_d;
    logic [7:0]           status_q, status_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [3:0]           io_out_q, io_out_d;
    logic [3:0]           io_oe_q, io_oe_d;
    logic                 cmd_done_q, cmd_done_d;
    logic                 recog_q, recog_d;
`ifdef SPI_RESP_QUAD_EN
    logic                 quad_q, quad_d;
`endif

    logic        sclk_rise_s, sclk_fall_s, cs_high_s, cs_fall_s, io0_s;
    logic [23:0] shift_in_s;
    logic [7:0]  src_byte_s, cur_byte_s;
    logic        byte_end_s;
    logic        unused_io_s;

    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_high_s   = cs_sync_q[1];
    assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
    assign io0_s       = io0_sync_q[1];
    assign shift_in_s  = {shift_q, io0_s};
    assign cur_byte_s  = (out_cnt_q == 3'd0) ? src_byte_s : out_sh_q;
    assign unused_io_s = ^io_in[3:1];

    // Byte presented at the start of each output byte; status is re-latched here every byte.
    always_comb begin
        case (src_q)
            SRC_STATUS: src_byte_s = status_q;
            SRC_JEDEC: begin
                case (jed_idx_q)
                    2'd0:    src_byte_s = JEDEC_ID[23:16];
                    2'd1:    src_byte_s = JEDEC_ID[15:8];
                    2'd2:    src_byte_s = JEDEC_ID[7:0];
                    default: src_byte_s = 8'h00;
                endcase
            end
            SRC_MEM:   src_byte_s = rdata_q;
            default:   src_byte_s = 8'h00;
        endcase
    end

    // Next-state logic: synchronisers, command FSM, status register and output shifter.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], CLOCK};
        cs_sync_d   = {cs_sync_q[1:0], CS};
        io0_sync_d  = {io0_sync_q[0], io_in[0]};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_cnt_d   = out_cnt_q;
        out_sh_d    = out_sh_q;
        src_d       = src_q;
        jed_idx_d   = jed_idx_q;
        status_d    = status_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        rd_pend_d   = mem_rd_q;
        rdata_d     = rd_pend_q ? mem_rdata : rdata_q;
        io_out_d    = io_out_q;
        io_oe_d     = io_oe_q;
        cmd_done_d  = 1'b0;
        recog_d     = recog_q;
        byte_end_s  = 1'b0;
`ifdef SPI_RESP_QUAD_EN
        quad_d      = quad_q;
`endif

        if (cs_high_s) begin
            // Deselect wins over any SCLK edge seen in the same cycle.
            state_d    = IDLE;
            bit_cnt_d  = 5'd0;
            out_cnt_d  = 3'd0;
            jed_idx_d  = 2'd0;
            io_oe_d    = 4'b0000;
            io_out_d   = 4'b0000;
            cmd_done_d = recog_q;
            recog_d    = 1'b0;
        end else if (cs_fall_s) begin
            state_d   = CMD;
            bit_cnt_d = 5'd0;
            recog_d   = 1'b0;
        end else begin
            case (state_q)
                CMD: begin
                    if (sclk_rise_s) begin
                        shift_d   = shift_in_s[22:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            out_cnt_d = 3'd0;
                            jed_idx_d = 2'd0;
                            recog_d   = 1'b1;
                            case (shift_in_s[7:0])
                                8'h06: begin
                                    status_d = {status_q[7:2], 1'b1, 1'b0};
                                    state_d  = IGNORE;
                                end
                                8'h04: begin
                                    status_d = {status_q[7:2], 1'b0, 1'b0};
                                    state_d  = IGNORE;
                                end
                                8'h05: begin
                                    src_d   = SRC_STATUS;
                                    state_d = DATA_OUT;
                                end
                                8'h9F: begin
                                    src_d   = SRC_JEDEC;
                                    state_d = DATA_OUT;
                                end
                                8'h01:   state_d = status_q[1] ? SR_WR : IGNORE;
                                8'h03: begin
                                    state_d = ADDR;
`ifdef SPI_RESP_QUAD_EN
                                    quad_d  = 1'b0;
`endif
                                end
`ifdef SPI_RESP_QUAD_EN
                                8'h6B: begin
                                    quad_d  = 1'b1;
                                    state_d = status_q[6] ? ADDR : IGNORE;
                                    recog_d = status_q[6];
                                end
`endif
                                default: begin
                                    state_d = IGNORE;
                                    recog_d = 1'b0;
                                end
                            endcase
                        end else begin
                            state_d = CMD;
                        end
                    end else begin
                        state_d = CMD;
                    end
                end
                SR_WR: begin
                    if (sclk_rise_s) begin
                        shift_d   = shift_in_s[22:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            status_d = {shift_in_s[7:2], 2'b00};
                            state_d  = IGNORE;
                        end else begin
                            state_d = SR_WR;
                        end
                    end else begin
                        state_d = SR_WR;
                    end
                end
                ADDR: begin
                    if (sclk_rise_s) begin
                        shift_d   = shift_in_s[22:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            mem_addr_d = shift_in_s[ADDR_SIZE-1:0];
                            mem_rd_d   = 1'b1;
                            src_d      = SRC_MEM;
                            bit_cnt_d  = 5'd0;
                            out_cnt_d  = 3'd0;
`ifdef SPI_RESP_QUAD_EN
                            state_d    = quad_q ? DUMMY : DATA_OUT;
`else
                            state_d    = DATA_OUT;
`endif
                        end else begin
                            state_d = ADDR;
                        end
                    end else begin
                        state_d = ADDR;
                    end
                end
`ifdef SPI_RESP_QUAD_EN
                DUMMY: begin
                    if (sclk_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = (bit_cnt_q == 5'd7) ? DATA_OUT : DUMMY;
                    end else begin
                        state_d = DUMMY;
                    end
                end
`endif
                DATA_OUT: begin
                    if (sclk_fall_s) begin
`ifdef SPI_RESP_QUAD_EN
                        if (quad_q) begin
                            io_out_d   = cur_byte_s[7:4];
                            io_oe_d    = 4'b1111;
                            out_sh_d   = {cur_byte_s[3:0], 4'h0};
                            out_cnt_d  = (out_cnt_q == 3'd1) ? 3'd0 : 3'd1;
                            byte_end_s = (out_cnt_q == 3'd1);
                        end else begin
                            io_out_d   = {2'b00, cur_byte_s[7], 1'b0};
                            io_oe_d    = 4'b0010;
                            out_sh_d   = {cur_byte_s[6:0], 1'b0};
                            out_cnt_d  = out_cnt_q + 3'd1;
                            byte_end_s = (out_cnt_q == 3'd7);
                        end
`else
                        io_out_d   = {2'b00, cur_byte_s[7], 1'b0};
                        io_oe_d    = 4'b0010;
                        out_sh_d   = {cur_byte_s[6:0], 1'b0};
                        out_cnt_d  = out_cnt_q + 3'd1;
                        byte_end_s = (out_cnt_q == 3'd7);
`endif
                        // Last fall of a byte: prefetch the next memory byte well ahead of its first fall.
                        if (byte_end_s) begin
                            if (src_q == SRC_MEM) begin
                                mem_addr_d = mem_addr_q + ADDR_ONE;
                                mem_rd_d   = 1'b1;
                            end else begin
                                mem_addr_d = mem_addr_q;
                            end
                            jed_idx_d = (jed_idx_q == 2'd3) ? jed_idx_q : jed_idx_q + 2'd1;
                        end else begin
                            jed_idx_d = jed_idx_q;
                        end
                    end else begin
                        state_d = DATA_OUT;
                    end
                end
                IDLE:    state_d = IDLE;
                IGNORE:  state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            io0_sync_q  <= 2'b00;
            state_q     <= IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 23'd0;
            out_cnt_q   <= 3'd0;
            out_sh_q    <= 8'h00;
            src_q       <= SRC_STATUS;
            jed_idx_q   <= 2'd0;
            status_q    <= 8'h00;
            mem_addr_q  <= {ADDR_SIZE{1'b0}};
            mem_rd_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            rdata_q     <= 8'h00;
            io_out_q    <= 4'b0000;
            io_oe_q     <= 4'b0000;
            cmd_done_q  <= 1'b0;
            recog_q     <= 1'b0;
`ifdef SPI_RESP_QUAD_EN
            quad_q      <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            io0_sync_q  <= io0_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_cnt_q   <= out_cnt_d;
            out_sh_q    <= out_sh_d;
            src_q       <= src_d;
            jed_idx_q   <= jed_idx_d;
            status_q    <= status_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            rd_pend_q   <= rd_pend_d;
            rdata_q     <= rdata_d;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
            cmd_done_q  <= cmd_done_d;
            recog_q     <= recog_d;
`ifdef SPI_RESP_QUAD_EN
            quad_q      <= quad_d;
`endif
        end
    end

    assign io_out     = io_out_q;
    assign io_oe      = io_oe_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign status_reg = status_q;
    assign cmd_done   = cmd_done_q;
endmodule
